meas_sweep_ctrl: RTL



---
 rtl/meas_sweep_pkg.sv | 20 ++
 rtl/meas_sync_edge.sv | 28 ++
 rtl/meas_sweep_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/meas_sweep_pkg.sv
// Shared types for the measurement sweep sequencer: FSM state encoding and
// the width helper used for point index / timeout count / blank-timeout counter.
package meas_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        BLANK,
        WAIT_SS,
        STROBE,
        NEXT,
        DONE
    } meas_sweep_state_t;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/meas_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level input, followed by a
// single-cycle rising-edge detect on the synchronized level.
module meas_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/meas_sweep_ctrl.sv
// Steady-state measurement sweep sequencer: steps a stimulus code over NUM_PTS
// points, blanks/arms the detector per point, strobes on detect, counts timeouts.
module meas_sweep_ctrl
    import meas_sweep_pkg::*;
#(
    parameter int NUM_PTS     = 8,
    parameter int CODE_W      = 8,
    parameter int CODE_START  = 0,
    parameter int CODE_STEP   = 1,
    parameter int BLANK_CYC   = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            ss_detect,
    output logic [CODE_W-1:0]               code_out,
    output logic                            arm,
    output logic                            strobe_req,
    output logic [cnt_width(NUM_PTS)-1:0]   point_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            to_flag,
    output logic [cnt_width(NUM_PTS)-1:0]   to_cnt
);

    localparam int IDX_W   = cnt_width(NUM_PTS);
    localparam int CNT_MAX = (BLANK_CYC > TIMEOUT_CYC) ? BLANK_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = cnt_width(CNT_MAX);

    meas_sweep_state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code_acc;
    logic              det_rise;
    logic              blank_end;
    logic              to_hit;
    logic              last_pt;
    logic              abort_now;

    meas_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (ss_detect),
        .rise     (det_rise)
    );

    assign blank_end = (cnt == '0);
    assign to_hit    = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign last_pt   = (point_idx == IDX_W'(NUM_PTS - 1));
    assign abort_now = abort && (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        arm        = 1'b0;
        strobe_req = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) next_state = APPLY;
            end
            APPLY:   next_state = BLANK;
            BLANK:   if (blank_end) next_state = WAIT_SS;
            WAIT_SS: begin
                arm = 1'b1;
                // A detect on the final timeout cycle still counts as a detect.
                if (det_rise)    next_state = STROBE;
                else if (to_hit) next_state = NEXT;
            end
            STROBE: begin
                arm        = 1'b1;
                strobe_req = 1'b1;
                next_state = NEXT;
            end
            NEXT:    next_state = last_pt ? DONE : APPLY;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (abort_now) next_state = IDLE;
    end

    // Datapath freezes on abort so the point/timeout status can be inspected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            code_acc  <= CODE_W'(CODE_START);
            code_out  <= CODE_W'(CODE_START);
            point_idx <= '0;
            to_flag   <= 1'b0;
            to_cnt    <= '0;
        end else if (!abort_now) begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        point_idx <= '0;
                        to_flag   <= 1'b0;
                        to_cnt    <= '0;
                        code_acc  <= CODE_W'(CODE_START);
                    end
                end
                APPLY: begin
                    code_out <= code_acc;
                    cnt      <= CNT_W'(BLANK_CYC - 1);
                end
                // Counter parks at zero on BLANK exit, so WAIT_SS times from 0.
                BLANK: begin
                    if (!blank_end) cnt <= cnt - 1'b1;
                end
                WAIT_SS: begin
                    if (!det_rise) begin
                        if (to_hit) begin
                            to_flag <= 1'b1;
                            to_cnt  <= to_cnt + IDX_W'(1);
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (!last_pt) begin
                        point_idx <= point_idx + IDX_W'(1);
                        code_acc  <= code_acc + CODE_W'(CODE_STEP);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
